// File: rtl/nic_ctrl.sv
// nic_ctrl: polls a register-mapped NIC, delivering received words to the host and draining a TX FIFO into it.
// Ports: clk/reset (sync, active-high); enable gates new service sequences;
//        tx_valid/tx_data/tx_ready/tx_count form the host TX FIFO push side;
//        rx_valid/rx_data/rx_ready hand one received word to the host;
//        nic_en/nic_wr_en/nic_addr/nic_d_in/nic_d_out drive the NIC register port.
module nic_ctrl #(
    parameter int TX_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        tx_valid,
    input  logic [63:0]                 tx_data,
    output logic                        tx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic                        rx_valid,
    output logic [63:0]                 rx_data,
    input  logic                        rx_ready,
    output logic                        nic_en,
    output logic                        nic_wr_en,
    output logic [1:0]                  nic_addr,
    output logic [63:0]                 nic_d_in,
    input  logic [63:0]                 nic_d_out
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW-1:0] P1 = AW'(1);
    localparam logic [AW:0]   C1 = (AW+1)'(1);

    typedef enum logic [2:0] {IDLE, RX_POLL, RX_CHK, RX_READ, RX_CAP, TX_POLL, TX_CHK, TX_WRITE} state_t;

    state_t        r_state, w_next;
    logic          r_pri, r_rx_valid;
    logic [63:0]   r_rx_data;
    logic [63:0]   r_mem [TX_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_rx_elig, w_tx_elig, w_push, w_pop;

    assign w_rx_elig = ~r_rx_valid;
    assign w_tx_elig = r_count != '0;
    // count never exceeds TX_DEPTH, so its MSB alone flags a full FIFO
    assign w_push    = tx_valid & ~r_count[AW];
    assign w_pop     = (r_state == TX_WRITE) & w_tx_elig;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = !enable ? IDLE :
                              (w_rx_elig && w_tx_elig) ? (r_pri ? TX_POLL : RX_POLL) :
                              w_rx_elig ? RX_POLL : w_tx_elig ? TX_POLL : IDLE;
            RX_POLL: w_next = RX_CHK;
            RX_CHK:  w_next = nic_d_out[63] ? RX_READ : IDLE;
            RX_READ: w_next = RX_CAP;
            TX_POLL: w_next = TX_CHK;
            TX_CHK:  w_next = nic_d_out[63] ? IDLE : TX_WRITE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pri      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == RX_POLL)
                r_pri <= 1'b1;
            else if (w_next == TX_POLL)
                r_pri <= 1'b0;
            if (r_state == RX_CAP && !r_rx_valid) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= nic_d_out;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_push)
                r_wptr <= r_wptr + P1;
            if (w_pop)
                r_rptr <= r_rptr + P1;
            if (w_push != w_pop)
                r_count <= w_push ? r_count + C1 : r_count - C1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= tx_data;
    end

    assign tx_ready  = ~r_count[AW];
    assign tx_count  = r_count;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign nic_en    = r_state inside {RX_POLL, RX_READ, TX_POLL, TX_WRITE};
    assign nic_wr_en = r_state == TX_WRITE;
    assign nic_addr  = (r_state == RX_POLL) ? 2'b01 :
                       (r_state == TX_POLL) ? 2'b11 :
                       (r_state == TX_WRITE) ? 2'b10 : 2'b00;
    assign nic_d_in  = (r_state == TX_WRITE) ? r_mem[r_rptr] : '0;
endmodule
